cdb_arbiter: RTL and testbench

Common-data-bus arbiter between the ALU and the load/store buffer result producers. Each producer pushes `(alias, result)` pairs into its own small FIFO. The arbiter grants one FIFO head per cycle onto a single registered CDB broadcast, alternating fairly when both producers have pending results. The CDB output feeds the reservation station, the LSB operand-forwarding logic and the ROB. With this block in place, those consumers snoop one bus instead of two.

---
 rtl/cdb_arbiter.sv | 135 +++++++++++++
 tb/tb_cdb_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: two small result FIFOs (ALU, LSB) feed one registered
// broadcast bus, with alternating priority whenever both producers are waiting.
module cdb_arbiter #(
    parameter int ID_WIDTH   = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  rollback_signal,
    input  logic                  alu_has_result,
    input  logic [ID_WIDTH-1:0]   alias_from_alu,
    input  logic [DATA_WIDTH-1:0] result_from_alu,
    output logic                  alu_stall,
    input  logic                  lsb_has_result,
    input  logic [ID_WIDTH-1:0]   alias_from_lsb,
    input  logic [DATA_WIDTH-1:0] result_from_lsb,
    output logic                  lsb_stall,
    output logic                  cdb_valid,
    output logic [ID_WIDTH-1:0]   cdb_alias,
    output logic [DATA_WIDTH-1:0] cdb_result,
    output logic                  cdb_from_lsb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ID_WIDTH + DATA_WIDTH;
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Producer index 0 is the ALU, index 1 is the LSB.
    logic [1:0]            push_req;
    logic [1:0]            full;
    logic [1:0]            nonempty;
    logic [1:0]            do_push;
    logic [1:0]            grant;
    logic [1:0][ENT_W-1:0] push_data;
    logic [1:0][ENT_W-1:0] head_data;
    logic [ENT_W-1:0]      grant_data;
    logic                  grant_lsb;
    logic                  last_lsb_reg;

    assign push_req     = {lsb_has_result, alu_has_result};
    assign push_data[0] = {alias_from_alu, result_from_alu};
    assign push_data[1] = {alias_from_lsb, result_from_lsb};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            logic [ENT_W-1:0] mem [DEPTH];
            logic [PTR_W-1:0] head_reg;
            logic [PTR_W-1:0] tail_reg;
            logic [PTR_W:0]   count_reg;
            logic             alias_valid;

            // Alias 0 means "no tag", so such a push carries nothing to broadcast.
            assign alias_valid   = (push_data[gi][ENT_W-1 -: ID_WIDTH] != '0);
            assign full[gi]      = (count_reg == CNT_FULL);
            assign nonempty[gi]  = (count_reg != '0);
            assign do_push[gi]   = rdy && !rollback_signal && push_req[gi]
                                   && !full[gi] && alias_valid;
            assign head_data[gi] = mem[head_reg];

            always_ff @(posedge clk) begin
                if (do_push[gi]) begin
                    mem[tail_reg] <= push_data[gi];
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    head_reg  <= '0;
                    tail_reg  <= '0;
                    count_reg <= '0;
                end else if (rollback_signal) begin
                    head_reg  <= '0;
                    tail_reg  <= '0;
                    count_reg <= '0;
                end else begin
                    if (do_push[gi]) begin
                        tail_reg <= tail_reg + PTR_ONE;
                    end
                    if (grant[gi]) begin
                        head_reg <= head_reg + PTR_ONE;
                    end
                    case ({do_push[gi], grant[gi]})
                        2'b10:   count_reg <= count_reg + CNT_ONE;
                        2'b01:   count_reg <= count_reg - CNT_ONE;
                        default: count_reg <= count_reg;
                    endcase
                end
            end
        end
    endgenerate

    // Full is judged on registered count only; a same-cycle pop does not free a slot.
    assign alu_stall = full[0];
    assign lsb_stall = full[1];

    // Grant looks only at pre-edge occupancy, so a fresh push is never bypassed.
    always_comb begin
        grant = 2'b00;
        if (rdy && !rollback_signal) begin
            if (nonempty[0] && nonempty[1]) begin
                grant = last_lsb_reg ? 2'b01 : 2'b10;
            end else if (nonempty[0]) begin
                grant = 2'b01;
            end else if (nonempty[1]) begin
                grant = 2'b10;
            end
        end
    end

    assign grant_lsb  = grant[1];
    assign grant_data = grant_lsb ? head_data[1] : head_data[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid    <= 1'b0;
            cdb_alias    <= '0;
            cdb_result   <= '0;
            cdb_from_lsb <= 1'b0;
            last_lsb_reg <= 1'b1;
        end else if (rollback_signal) begin
            cdb_valid <= 1'b0;
        end else if (rdy) begin
            cdb_valid <= |grant;
            if (|grant) begin
                {cdb_alias, cdb_result} <= grant_data;
                cdb_from_lsb            <= grant_lsb;
                last_lsb_reg            <= grant_lsb;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then random traffic, every cycle
// compared against a queue-based reference model of the arbitration rules.
module tb_cdb_arbiter;
    localparam int ID_WIDTH   = 5;
    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  rdy = 1'b0;
    logic                  rollback_signal = 1'b0;
    logic                  alu_has_result = 1'b0;
    logic [ID_WIDTH-1:0]   alias_from_alu = '0;
    logic [DATA_WIDTH-1:0] result_from_alu = '0;
    logic                  lsb_has_result = 1'b0;
    logic [ID_WIDTH-1:0]   alias_from_lsb = '0;
    logic [DATA_WIDTH-1:0] result_from_lsb = '0;
    logic                  alu_stall;
    logic                  lsb_stall;
    logic                  cdb_valid;
    logic [ID_WIDTH-1:0]   cdb_alias;
    logic [DATA_WIDTH-1:0] cdb_result;
    logic                  cdb_from_lsb;

    cdb_arbiter #(.ID_WIDTH(ID_WIDTH), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback_signal(rollback_signal),
        .alu_has_result(alu_has_result), .alias_from_alu(alias_from_alu),
        .result_from_alu(result_from_alu), .alu_stall(alu_stall),
        .lsb_has_result(lsb_has_result), .alias_from_lsb(alias_from_lsb),
        .result_from_lsb(result_from_lsb), .lsb_stall(lsb_stall),
        .cdb_valid(cdb_valid), .cdb_alias(cdb_alias), .cdb_result(cdb_result),
        .cdb_from_lsb(cdb_from_lsb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   a;
        logic [DATA_WIDTH-1:0] d;
    } ent_t;

    ent_t                  alu_q[$];
    ent_t                  lsb_q[$];
    logic                  m_last_lsb;
    logic                  m_valid;
    logic [ID_WIDTH-1:0]   m_alias;
    logic [DATA_WIDTH-1:0] m_result;
    logic                  m_from_lsb;
    int                    n_assert = 0;
    int                    n_fail = 0;
    int                    cyc = 0;
    bit                    saw_alias9 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        alu_q.delete();
        lsb_q.delete();
        m_last_lsb = 1'b1;
        m_valid    = 1'b0;
        m_alias    = '0;
        m_result   = '0;
        m_from_lsb = 1'b0;
    endtask

    // Applies the arbitration rules to the inputs present just before the edge.
    task automatic model_edge();
        bit   pa, pl, ga, gl;
        ent_t e;
        if (!rst) begin
            model_reset();
            return;
        end
        if (rollback_signal) begin
            alu_q.delete();
            lsb_q.delete();
            m_valid = 1'b0;
            return;
        end
        if (!rdy) return;
        pa = alu_has_result && (alu_q.size() < DEPTH) && (alias_from_alu != 0);
        pl = lsb_has_result && (lsb_q.size() < DEPTH) && (alias_from_lsb != 0);
        ga = (alu_q.size() != 0) && ((lsb_q.size() == 0) || m_last_lsb);
        gl = (lsb_q.size() != 0) && !ga;
        m_valid = ga || gl;
        if (ga) begin
            e = alu_q.pop_front();
            m_alias = e.a; m_result = e.d; m_from_lsb = 1'b0; m_last_lsb = 1'b0;
        end else if (gl) begin
            e = lsb_q.pop_front();
            m_alias = e.a; m_result = e.d; m_from_lsb = 1'b1; m_last_lsb = 1'b1;
        end
        if (pa) begin
            e.a = alias_from_alu; e.d = result_from_alu;
            alu_q.push_back(e);
        end
        if (pl) begin
            e.a = alias_from_lsb; e.d = result_from_lsb;
            lsb_q.push_back(e);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 64'(cdb_valid), 64'(m_valid));
        chk({tag, ".alias"}, 64'(cdb_alias), 64'(m_alias));
        chk({tag, ".result"}, 64'(cdb_result), 64'(m_result));
        chk({tag, ".from_lsb"}, 64'(cdb_from_lsb), 64'(m_from_lsb));
        chk({tag, ".alu_stall"}, 64'(alu_stall), 64'(alu_q.size() == DEPTH));
        chk({tag, ".lsb_stall"}, 64'(lsb_stall), 64'(lsb_q.size() == DEPTH));
        if (cdb_valid && cdb_from_lsb && cdb_alias == 9) saw_alias9 = 1;
        $display("cyc %0d %s: valid=%0b alias=%0d result=%h lsb=%0b stall=%0b%0b qa=%0d ql=%0d",
                 cyc, tag, cdb_valid, cdb_alias, cdb_result, cdb_from_lsb,
                 alu_stall, lsb_stall, alu_q.size(), lsb_q.size());
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        check_all(tag);
    endtask

    task automatic idle();
        alu_has_result = 1'b0;
        lsb_has_result = 1'b0;
        rollback_signal = 1'b0;
    endtask

    task automatic push_alu(input int a, input logic [DATA_WIDTH-1:0] d);
        alu_has_result = 1'b1; alias_from_alu = ID_WIDTH'(a); result_from_alu = d;
    endtask

    task automatic push_lsb(input int a, input logic [DATA_WIDTH-1:0] d);
        lsb_has_result = 1'b1; alias_from_lsb = ID_WIDTH'(a); result_from_lsb = d;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step("reset");
        rst = 1'b1;
        rdy = 1'b1;
    endtask

    initial begin
        int exp_order[4];
        int lsb_alias;
        exp_order = '{1, 5, 2, 6};
        model_reset();
        #1;
        check_all("por");
        do_reset();

        // Single ALU result: visible only after the second edge.
        push_alu(3, 32'h12345678);
        step("single_push");
        idle();
        step("single_bcast");
        chk("single_valid", 64'(cdb_valid), 64'd1);
        chk("single_alias", 64'(cdb_alias), 64'd3);
        chk("single_result", 64'(cdb_result), 64'h12345678);
        step("single_after");
        chk("single_pulse", 64'(cdb_valid), 64'd0);

        // Contention from a fresh reset: ALU wins the first tie, then strict alternation.
        do_reset();
        push_alu(1, 32'hA1); push_lsb(5, 32'hB5);
        step("cont_push1");
        push_alu(2, 32'hA2); push_lsb(6, 32'hB6);
        step("cont_push2");
        chk("cont_order0", 64'(cdb_alias), 64'(exp_order[0]));
        idle();
        for (int i = 1; i < 4; i++) begin
            step("cont_drain");
            chk("cont_order", 64'(cdb_alias), 64'(exp_order[i]));
            chk("cont_valid", 64'(cdb_valid), 64'd1);
        end
        step("cont_empty");

        // Fill the LSB FIFO under ALU contention, then try a push while full.
        lsb_alias = 1;
        for (int i = 0; i < 20 && lsb_q.size() < DEPTH; i++) begin
            push_alu(10 + (i % 8), $urandom);
            push_lsb(lsb_alias, $urandom);
            lsb_alias++;
            step("fill");
        end
        chk("fill_stall", 64'(lsb_stall), 64'd1);
        idle();
        push_lsb(9, 32'hDEAD0009);
        step("full_drop");
        idle();
        for (int i = 0; i < 12; i++) step("fill_drain");
        for (int i = 0; i < 6; i++) begin
            push_lsb(20 + i, 32'h100 + 32'(i));
            step("wrap_push");
        end
        idle();
        for (int i = 0; i < 4; i++) step("wrap_drain");
        chk("alias9_dropped", 64'(saw_alias9), 64'd0);

        // Pause with a valid broadcast and two queued LSB entries.
        do_reset();
        push_alu(1, 32'h11); push_lsb(5, 32'h55);
        step("pause_setup1");
        idle();
        push_lsb(6, 32'h66);
        step("pause_setup2");
        rdy = 1'b0;
        push_alu(7, 32'h77); push_lsb(8, 32'h88);
        for (int i = 0; i < 3; i++) begin
            step("paused");
            chk("pause_hold_valid", 64'(cdb_valid), 64'd1);
            chk("pause_hold_alias", 64'(cdb_alias), 64'd1);
        end
        idle();
        rdy = 1'b1;
        step("resume");
        chk("resume_alias", 64'(cdb_alias), 64'd5);
        for (int i = 0; i < 3; i++) step("resume_drain");

        // Rollback with several queued entries and a same-cycle push.
        for (int i = 0; i < 20 && !(alu_q.size() >= 3 && lsb_q.size() >= 2); i++) begin
            push_alu(1 + (i % 15), $urandom);
            push_lsb(16 + (i % 15), $urandom);
            step("rb_fill");
        end
        rollback_signal = 1'b1;
        step("rollback");
        chk("rb_valid", 64'(cdb_valid), 64'd0);
        chk("rb_stall", 64'({alu_stall, lsb_stall}), 64'd0);
        idle();
        for (int i = 0; i < 6; i++) step("rb_after");

        // Asynchronous reset mid-cycle with entries queued.
        push_alu(4, 32'h44); push_lsb(12, 32'hCC);
        step("ar_push1");
        step("ar_push2");
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        chk("ar_valid", 64'(cdb_valid), 64'd0);
        idle();
        step("ar_hold");
        rst = 1'b1;
        for (int i = 0; i < 10; i++) step("ar_idle");

        // Random traffic, including pushes while full, alias 0, pauses and rollbacks.
        for (int i = 0; i < 1500; i++) begin
            rdy             = ($urandom_range(0, 99) < 85);
            rollback_signal = ($urandom_range(0, 99) < 3);
            alu_has_result  = ($urandom_range(0, 99) < 60);
            lsb_has_result  = ($urandom_range(0, 99) < 60);
            alias_from_alu  = ID_WIDTH'($urandom_range(0, 31));
            alias_from_lsb  = ID_WIDTH'($urandom_range(0, 31));
            result_from_alu = $urandom;
            result_from_lsb = $urandom;
            step("rand");
        end
        idle();
        rdy = 1'b1;
        for (int i = 0; i < 10; i++) step("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
